// File: rtl/vxe_axi_switch_us_arb.sv
// rtl/vxe_axi_switch_us_arb.sv - upstream round-robin request arbiter of the VxE AXI switch.
// Optional outstanding-read throttling is enabled by defining VXE_AXI_US_ARB_OUTST_EN.
module vxe_axi_switch_us_arb #(
    parameter int NCLI         = 4,
    parameter int RQA_W        = 44,
    parameter int RQD_W        = 64,
    parameter int MAX_RD_OUTST = 4
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [NCLI*RQA_W-1:0] i_rqa,
    input  logic [NCLI-1:0]       i_rqa_vld,
    output logic [NCLI-1:0]       o_rqa_rdy,
    input  logic [NCLI*RQD_W-1:0] i_rqd,
    input  logic [NCLI-1:0]       i_rqd_vld,
    output logic [NCLI-1:0]       o_rqd_rdy,
    output logic [RQA_W-1:0]      o_biu_rqa,
    output logic                  o_biu_rqa_push,
    input  logic                  i_biu_rqa_ready,
    output logic [RQD_W-1:0]      o_biu_rqd,
    output logic                  o_biu_rqd_push,
    input  logic                  i_biu_rqd_ready,
    output logic [2:0]            o_gnt_id,
    output logic                  o_busy
`ifdef VXE_AXI_US_ARB_OUTST_EN
    ,
    input  logic                  i_rd_retire
`endif
);

    localparam int CW = (NCLI > 1) ? $clog2(NCLI) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_DATA  = 2'd2,
        ST_WAITD = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]     gnt_q, gnt_d;
    logic [RQA_W-1:0]  rqa_q, rqa_d;
    logic [RQD_W-1:0]  rqd_q, rqd_d;
    logic              rqa_push_q, rqa_push_d;
    logic              rqd_push_q, rqd_push_d;

    logic [NCLI-1:0]   elig;
    logic              win_vld;
    logic [CW-1:0]     win_idx;

`ifdef VXE_AXI_US_ARB_OUTST_EN
    localparam int CNT_W = $clog2(MAX_RD_OUTST + 1);

    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic              rd_inc, rd_dec, rd_full;

    assign rd_inc  = rqa_push_q && i_biu_rqa_ready && rqa_q[RQA_W-1];
    assign rd_dec  = i_rd_retire && (rd_cnt_q != '0);
    assign rd_full = (rd_cnt_q == CNT_W'(MAX_RD_OUTST));

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        if (rd_inc && !rd_dec) begin
            rd_cnt_d = rd_cnt_q + 1'b1;
        end else if (rd_dec && !rd_inc) begin
            rd_cnt_d = rd_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            rd_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
        end
    end
`endif

    // Reads are hidden from the scan while the outstanding-read budget is spent.
    always_comb begin
        for (int c = 0; c < NCLI; c++) begin
            elig[c] = i_rqa_vld[c];
`ifdef VXE_AXI_US_ARB_OUTST_EN
            if (rd_full && i_rqa[c*RQA_W + RQA_W - 1]) begin
                elig[c] = 1'b0;
            end
`endif
        end
    end

    // Scan downward so the client nearest rr_ptr is the last (winning) assignment.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = NCLI - 1; i >= 0; i--) begin
            int idx;
            idx = int'(rr_ptr_q) + i;
            if (idx >= NCLI) begin
                idx = idx - NCLI;
            end
            if (elig[CW'(idx)]) begin
                win_vld = 1'b1;
                win_idx = CW'(idx);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_d      = gnt_q;
        rqa_d      = rqa_q;
        rqd_d      = rqd_q;
        rqa_push_d = rqa_push_q;
        rqd_push_d = rqd_push_q;
        o_rqa_rdy  = '0;
        o_rqd_rdy  = '0;

        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    o_rqa_rdy[win_idx] = 1'b1;
                    rqa_d      = i_rqa[win_idx*RQA_W +: RQA_W];
                    rqa_push_d = 1'b1;
                    gnt_d      = win_idx;
                    rr_ptr_d   = (win_idx == CW'(NCLI - 1)) ? '0 : win_idx + 1'b1;
                    state_d    = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (i_biu_rqa_ready) begin
                    rqa_push_d = 1'b0;
                    state_d    = rqa_q[RQA_W-1] ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                o_rqd_rdy[gnt_q] = 1'b1;
                if (i_rqd_vld[gnt_q]) begin
                    rqd_d      = i_rqd[gnt_q*RQD_W +: RQD_W];
                    rqd_push_d = 1'b1;
                    state_d    = ST_WAITD;
                end
            end
            ST_WAITD: begin
                if (i_biu_rqd_ready) begin
                    rqd_push_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // No client may see an accept while reset is asserted.
        if (!nrst) begin
            o_rqa_rdy = '0;
            o_rqd_rdy = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            gnt_q      <= '0;
            rqa_push_q <= 1'b0;
            rqd_push_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_q      <= gnt_d;
            rqa_push_q <= rqa_push_d;
            rqd_push_q <= rqd_push_d;
        end
    end

    // Payload registers carry no reset; their push flags qualify them.
    always_ff @(posedge clk) begin
        rqa_q <= rqa_d;
        rqd_q <= rqd_d;
    end

    assign o_biu_rqa      = rqa_q;
    assign o_biu_rqa_push = rqa_push_q;
    assign o_biu_rqd      = rqd_q;
    assign o_biu_rqd_push = rqd_push_q;
    assign o_gnt_id       = 3'(gnt_q);
    assign o_busy         = (state_q != ST_IDLE);

endmodule
